// File: rtl/population_memory.sv
// Population store for the GA core: chromosome/fitness slots, saturated fitness total,
// registered parent reads and a start/done offspring write port. Option: REPLACE_WORST_EN.
module population_memory #(
    parameter int CHROMOSOME_WIDTH = 16,
    parameter int FITNESS_WIDTH    = 14,
    parameter int POPULATION_SIZE  = 16,
    parameter int ADDR_WIDTH       = $clog2(POPULATION_SIZE)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start_write,
    input  logic [CHROMOSOME_WIDTH-1:0]                   child_in,
    input  logic [FITNESS_WIDTH-1:0]                      child_fitness_in,
    input  logic [ADDR_WIDTH-1:0]                         read_addr1,
    input  logic [ADDR_WIDTH-1:0]                         read_addr2,
    output logic [CHROMOSOME_WIDTH-1:0]                   parent1_out,
    output logic [CHROMOSOME_WIDTH-1:0]                   parent2_out,
    output logic [POPULATION_SIZE-1:0][FITNESS_WIDTH-1:0] fitness_values,
    output logic [FITNESS_WIDTH-1:0]                      total_fitness,
    output logic [ADDR_WIDTH:0]                           population_count,
    output logic                                          population_full,
    output logic                                          busy,
    output logic                                          write_done,
    output logic                                          write_accepted
);

    localparam int ACC_W = FITNESS_WIDTH + ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The accumulator is wide enough for the exact sum; only the published total clips.
    function automatic logic [FITNESS_WIDTH-1:0] sat_total(input logic [ACC_W-1:0] acc);
        if (|acc[ACC_W-1:FITNESS_WIDTH]) begin
            return '1;
        end
        return acc[FITNESS_WIDTH-1:0];
    endfunction

    state_t                      state_q, state_d;
    logic [CHROMOSOME_WIDTH-1:0] mem_q [POPULATION_SIZE];
    logic [CHROMOSOME_WIDTH-1:0] mem_d [POPULATION_SIZE];
    logic [FITNESS_WIDTH-1:0]    fit_q [POPULATION_SIZE];
    logic [FITNESS_WIDTH-1:0]    fit_d [POPULATION_SIZE];
    logic [ACC_W-1:0]            acc_q, acc_d;
    logic [ADDR_WIDTH-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [CHROMOSOME_WIDTH-1:0] child_q, child_d;
    logic [FITNESS_WIDTH-1:0]    child_fit_q, child_fit_d;
    logic [ADDR_WIDTH-1:0]       tgt_q, tgt_d;
    logic                        accept_q, accept_d;
    logic [CHROMOSOME_WIDTH-1:0] parent1_q, parent1_d;
    logic [CHROMOSOME_WIDTH-1:0] parent2_q, parent2_d;

    logic                        full;
    logic [ADDR_WIDTH-1:0]       ptr_next;
    logic [ADDR_WIDTH-1:0]       req_tgt;
    logic                        req_accept;

    assign full     = (count_q == CNT_W'(POPULATION_SIZE));
    assign ptr_next = (wr_ptr_q == ADDR_WIDTH'(POPULATION_SIZE - 1)) ? '0 : wr_ptr_q + 1'b1;

`ifdef REPLACE_WORST_EN
    logic [FITNESS_WIDTH-1:0] min_fit;
    logic [ADDR_WIDTH-1:0]    min_idx;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_fit = fit_q[0];
        min_idx = '0;
        for (int i = 1; i < POPULATION_SIZE; i++) begin
            if (fit_q[i] < min_fit) begin
                min_fit = fit_q[i];
                min_idx = ADDR_WIDTH'(i);
            end
        end
    end

    always_comb begin
        req_tgt    = wr_ptr_q;
        req_accept = 1'b1;
        if (full) begin
            req_tgt    = min_idx;
            req_accept = (child_fitness_in > min_fit);
        end
    end
`else
    // Round-robin: once full, wr_ptr has wrapped and simply keeps overwriting.
    always_comb begin
        req_tgt    = wr_ptr_q;
        req_accept = 1'b1;
    end
`endif

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        fit_d       = fit_q;
        acc_d       = acc_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        child_d     = child_q;
        child_fit_d = child_fit_q;
        tgt_d       = tgt_q;
        accept_d    = accept_q;
        parent1_d   = mem_q[read_addr1];
        parent2_d   = mem_q[read_addr2];

        unique case (state_q)
            IDLE: begin
                if (start_write) begin
                    child_d     = child_in;
                    child_fit_d = child_fitness_in;
                    tgt_d       = req_tgt;
                    accept_d    = req_accept;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                if (accept_q) begin
                    mem_d[tgt_q] = child_q;
                    fit_d[tgt_q] = child_fit_q;
                    acc_d        = acc_q - ACC_W'(fit_q[tgt_q]) + ACC_W'(child_fit_q);
                    wr_ptr_d     = ptr_next;
                    if (!full) begin
                        count_d = count_q + 1'b1;
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_q       <= '{default: '0};
            fit_q       <= '{default: '0};
            acc_q       <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            child_q     <= '0;
            child_fit_q <= '0;
            tgt_q       <= '0;
            accept_q    <= 1'b0;
            parent1_q   <= '0;
            parent2_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            fit_q       <= fit_d;
            acc_q       <= acc_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            child_q     <= child_d;
            child_fit_q <= child_fit_d;
            tgt_q       <= tgt_d;
            accept_q    <= accept_d;
            parent1_q   <= parent1_d;
            parent2_q   <= parent2_d;
        end
    end

    always_comb begin
        for (int i = 0; i < POPULATION_SIZE; i++) begin
            fitness_values[i] = fit_q[i];
        end
    end

    assign parent1_out      = parent1_q;
    assign parent2_out      = parent2_q;
    assign total_fitness    = sat_total(acc_q);
    assign population_count = count_q;
    assign population_full  = full;
    assign busy             = (state_q != IDLE);
    assign write_done       = (state_q == DONE);
    assign write_accepted   = (state_q == DONE) && accept_q;

endmodule

// File: tb/tb_population_memory.sv
// Directed bench for population_memory: reset, fill, reads, full-population policy,
// saturation, reset abort and busy-time requests. Follows REPLACE_WORST_EN if defined.
module tb_population_memory;

    localparam int CW = 16;
    localparam int FW = 14;
    localparam int PS = 16;
    localparam int AW = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start_write;
    logic [CW-1:0]           child_in;
    logic [FW-1:0]           child_fitness_in;
    logic [AW-1:0]           read_addr1;
    logic [AW-1:0]           read_addr2;
    logic [CW-1:0]           parent1_out;
    logic [CW-1:0]           parent2_out;
    logic [PS-1:0][FW-1:0]   fitness_values;
    logic [FW-1:0]           total_fitness;
    logic [AW:0]             population_count;
    logic                    population_full;
    logic                    busy;
    logic                    write_done;
    logic                    write_accepted;

    int n_tests = 0;
    int n_fail  = 0;

    population_memory #(
        .CHROMOSOME_WIDTH(CW),
        .FITNESS_WIDTH   (FW),
        .POPULATION_SIZE (PS),
        .ADDR_WIDTH      (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_write     (start_write),
        .child_in        (child_in),
        .child_fitness_in(child_fitness_in),
        .read_addr1      (read_addr1),
        .read_addr2      (read_addr2),
        .parent1_out     (parent1_out),
        .parent2_out     (parent2_out),
        .fitness_values  (fitness_values),
        .total_fitness   (total_fitness),
        .population_count(population_count),
        .population_full (population_full),
        .busy            (busy),
        .write_done      (write_done),
        .write_accepted  (write_accepted)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start_write = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Called #1 after an edge with the DUT idle; returns after the done pulse has ended.
    task automatic do_write(input logic [CW-1:0] ch, input logic [FW-1:0] f, output logic acc);
        int lat;
        child_in         = ch;
        child_fitness_in = f;
        start_write      = 1'b1;
        tick();
        start_write = 1'b0;
        lat = 1;
        while (!write_done && lat < 8) begin
            tick();
            lat++;
        end
        check_val("wr_latency", 64'(lat), 64'(2));
        acc = write_accepted;
        tick();
        check_val("done_pulse_end", 64'({write_done, busy}), 64'(0));
    endtask

    logic          acc_flag;
    logic          all_acc;
    logic          all_max;
    logic          seen_done;
    int            rslot;
    logic [CW-1:0] old_chrom;
    logic [FW-1:0] new_fit;
    logic [FW-1:0] exp_total;

    initial begin
        rst              = 1'b1;
        start_write      = 1'b0;
        child_in         = '0;
        child_fitness_in = '0;
        read_addr1       = '0;
        read_addr2       = '0;

        // Reset state
        tick();
        tick();
        check_val("rst_parent1", 64'(parent1_out), 64'(0));
        check_val("rst_parent2", 64'(parent2_out), 64'(0));
        check_val("rst_total", 64'(total_fitness), 64'(0));
        check_val("rst_count", 64'(population_count), 64'(0));
        check_val("rst_flags", 64'({population_full, busy, write_done, write_accepted}), 64'(0));
        check_val("rst_fitvals", 64'(|fitness_values), 64'(0));
        rst = 1'b0;
        tick();

        // Fill: chrom=i, fitness=100
        all_acc = 1'b1;
        for (int i = 0; i < PS; i++) begin
            do_write(CW'(i), FW'(100), acc_flag);
            all_acc = all_acc & acc_flag;
            if (i == PS - 2) check_val("not_full_15", 64'(population_full), 64'(0));
        end
        check_val("fill_accepted", 64'(all_acc), 64'(1));
        check_val("fill_total", 64'(total_fitness), 64'(1600));
        check_val("fill_count", 64'(population_count), 64'(16));
        check_val("fill_full", 64'(population_full), 64'(1));
        check_val("fill_fit15", 64'(fitness_values[15]), 64'(100));

        // Registered reads
        read_addr1 = 4'd3;
        read_addr2 = 4'd7;
        tick();
        check_val("rd_p1", 64'(parent1_out), 64'(3));
        check_val("rd_p2", 64'(parent2_out), 64'(7));
        read_addr1 = 4'd5;
        read_addr2 = 4'd5;
        tick();
        check_val("rd_same_p1", 64'(parent1_out), 64'(5));
        check_val("rd_same_p2", 64'(parent2_out), 64'(5));

`ifdef REPLACE_WORST_EN
        do_reset();
        for (int i = 0; i < PS; i++) begin
            do_write(CW'(i), (i == 5) ? FW'(10) : FW'(100), acc_flag);
        end
        check_val("worst_base_total", 64'(total_fitness), 64'(1510));
        read_addr1 = 4'd5;
        do_write(16'hBEEF, FW'(500), acc_flag);
        check_val("worst_acc", 64'(acc_flag), 64'(1));
        check_val("worst_total", 64'(total_fitness), 64'(2000));
        check_val("worst_fit5", 64'(fitness_values[5]), 64'(500));
        tick();
        check_val("worst_chrom5", 64'(parent1_out), 64'(16'hBEEF));
        do_write(16'h1234, FW'(5), acc_flag);
        check_val("reject_acc", 64'(acc_flag), 64'(0));
        check_val("reject_total", 64'(total_fitness), 64'(2000));
        check_val("reject_fit5", 64'(fitness_values[5]), 64'(500));
        check_val("reject_count", 64'(population_count), 64'(16));
        // Next target: all remaining at 100, lowest index (slot 0) wins the tie
        rslot     = 0;
        old_chrom = 16'd0;
        new_fit   = FW'(200);
        exp_total = FW'(2100);
`else
        read_addr1 = 4'd0;
        do_write(16'hAAAA, FW'(50), acc_flag);
        check_val("wrap_acc", 64'(acc_flag), 64'(1));
        check_val("wrap_total", 64'(total_fitness), 64'(1550));
        check_val("wrap_fit0", 64'(fitness_values[0]), 64'(50));
        check_val("wrap_count", 64'(population_count), 64'(16));
        tick();
        check_val("wrap_chrom0", 64'(parent1_out), 64'(16'hAAAA));
        // Round-robin continues at slot 1
        rslot     = 1;
        old_chrom = 16'd1;
        new_fit   = FW'(100);
        exp_total = FW'(1550);
`endif

        // Read of the slot being written returns old data at E1, new data one cycle later
        read_addr1       = AW'(rslot);
        child_in         = 16'h5555;
        child_fitness_in = new_fit;
        start_write      = 1'b1;
        tick();
        start_write = 1'b0;
        tick();
        check_val("rdw_old", 64'(parent1_out), 64'(old_chrom));
        check_val("rdw_done", 64'(write_done), 64'(1));
        tick();
        check_val("rdw_new", 64'(parent1_out), 64'(16'h5555));
        check_val("rdw_total", 64'(total_fitness), 64'(exp_total));

        // Saturation
        do_reset();
        all_max = 1'b1;
        for (int i = 0; i < PS; i++) begin
            do_write(CW'(i), FW'(16383), acc_flag);
            if (i == 1) check_val("sat_two", 64'(total_fitness), 64'(16383));
        end
        for (int i = 0; i < PS; i++) begin
            all_max = all_max & (fitness_values[i] == FW'(16383));
        end
        check_val("sat_total", 64'(total_fitness), 64'(16383));
        check_val("sat_fitvals", 64'(all_max), 64'(1));

        // Reset during WRITE aborts the request and clears slots
        do_reset();
        do_write(16'd7, FW'(77), acc_flag);
        check_val("abort_pre_fit0", 64'(fitness_values[0]), 64'(77));
        child_in         = 16'd9;
        child_fitness_in = FW'(88);
        start_write      = 1'b1;
        tick();
        start_write = 1'b0;
        #2 rst = 1'b1;
        tick();
        check_val("abort_busy", 64'({busy, write_done}), 64'(0));
        check_val("abort_fit0", 64'(fitness_values[0]), 64'(0));
        check_val("abort_count", 64'(population_count), 64'(0));
        check_val("abort_total", 64'(total_fitness), 64'(0));
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_done = seen_done | write_done;
        end
        check_val("abort_no_done", 64'(seen_done), 64'(0));

        // start_write while busy is ignored
        child_in         = 16'd1;
        child_fitness_in = FW'(20);
        start_write      = 1'b1;
        tick();
        child_in         = 16'd2;
        child_fitness_in = FW'(999);
        tick();
        start_write = 1'b0;
        check_val("busy_done", 64'({write_done, write_accepted}), 64'(3));
        tick();
        check_val("busy_idle", 64'(busy), 64'(0));
        check_val("busy_count", 64'(population_count), 64'(1));
        check_val("busy_total", 64'(total_fitness), 64'(20));
        check_val("busy_fit1", 64'(fitness_values[1]), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
